// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants, FSM state encoding and lane helpers for the
// memory bus master (mem_bus_ctrl) and its byte merge unit.
package mem_bus_pkg;

   localparam int DATA_W      = 32;
   localparam int NUM_LANES   = 4;
   localparam int ADDR_W_DFLT = 7;

   // Controller state encoding (kept as plain constants for legacy tooling).
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RD     = 3'd1;
   localparam logic [2:0] ST_WR     = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   // Expand one enable bit per byte lane into a full-width bit mask.
   function automatic logic [DATA_W-1:0] lane_mask(input logic [NUM_LANES-1:0] be);
      logic [DATA_W-1:0] m;
      m = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_byte_merge.sv
// byte_merge: combinational lane merge for sub-word stores. Enabled lanes are
// taken from the new word, the remaining lanes keep the old memory word.
// Only present when BYTE_STORE_EN is defined.
`ifdef BYTE_STORE_EN
module byte_merge
   import mem_bus_pkg::*;
(
   input  logic [DATA_W-1:0]    old_word,
   input  logic [DATA_W-1:0]    new_word,
   input  logic [NUM_LANES-1:0] be,
   output logic [DATA_W-1:0]    merged_word
);

   logic [DATA_W-1:0] mask_s;

   assign mask_s      = lane_mask(be);
   assign merged_word = (new_word & mask_s) | (old_word & ~mask_s);

endmodule
`endif

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-request bus master in front of the shared word memory.
// Turns valid/ready load/store requests into CS/WE/ADDR bus cycles, owns the
// tri-state drive of Mem_Bus and returns a one-cycle resp_valid pulse.
// Optional feature macro: BYTE_STORE_EN (sub-word stores by read-modify-write;
// without it req_be is ignored and every store writes the full word).
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [31:0]          req_addr,
   input  logic [NUM_LANES-1:0] req_be,
   input  logic [DATA_W-1:0]    req_wdata,
   output logic                 resp_valid,
   output logic [DATA_W-1:0]    resp_rdata,
   output logic                 CS,
   output logic                 WE,
   output logic [ADDR_W-1:0]    ADDR,
   inout  wire  [DATA_W-1:0]    Mem_Bus
);

   logic [2:0]        state_r;
   logic [2:0]        next_s;
   logic [2:0]        target_s;
   logic              accept_s;
   logic              cs_nx_s;
   logic              we_nx_s;
   logic              cs_r;
   logic              we_r;
   logic              ready_r;
   logic              resp_valid_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] bus_dout_r;
   logic [DATA_W-1:0] rdata_r;
   logic              unused_s;
`ifdef BYTE_STORE_EN
   logic [NUM_LANES-1:0] be_r;
   logic [DATA_W-1:0]    merged_s;
`endif

   // IDLE and RESP both accept; ready_r is the registered view of that.
   assign accept_s = req_valid && ready_r;

`ifdef BYTE_STORE_EN
   // Merge the word the memory is returning with the pending store data.
   byte_merge u_byte_merge (
      .old_word    (Mem_Bus),
      .new_word    (bus_dout_r),
      .be          (be_r),
      .merged_word (merged_s)
   );
`endif

   // Select the first state of a newly accepted request.
   always_comb begin
      if (!req_we) begin
         target_s = ST_RD;
      end
`ifdef BYTE_STORE_EN
      else if (req_be == 4'b1111) begin
         target_s = ST_WR;
      end else if (req_be == 4'b0000) begin
         target_s = ST_RESP;
      end else begin
         target_s = ST_RMW_RD;
      end
`else
      else begin
         target_s = ST_WR;
      end
`endif
   end

   // Next-state logic of the bus sequencing FSM.
   always_comb begin
      next_s = ST_IDLE;
      case (state_r)
         ST_IDLE, ST_RESP: begin
            if (accept_s) begin
               next_s = target_s;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_RD:     next_s = ST_RESP;
         ST_WR:     next_s = ST_RESP;
`ifdef BYTE_STORE_EN
         ST_RMW_RD: next_s = ST_RMW_WR;
         ST_RMW_WR: next_s = ST_RESP;
`endif
         default:   next_s = ST_IDLE;
      endcase
   end

   // Decode bus strobes for the upcoming state so they are registered.
   always_comb begin
      cs_nx_s = 1'b0;
      we_nx_s = 1'b0;
      case (next_s)
         ST_RD: begin
            cs_nx_s = 1'b1;
         end
         ST_WR: begin
            cs_nx_s = 1'b1;
            we_nx_s = 1'b1;
         end
`ifdef BYTE_STORE_EN
         ST_RMW_RD: begin
            cs_nx_s = 1'b1;
         end
         ST_RMW_WR: begin
            cs_nx_s = 1'b1;
            we_nx_s = 1'b1;
         end
`endif
         default: begin
            cs_nx_s = 1'b0;
            we_nx_s = 1'b0;
         end
      endcase
   end

   // State, registered outputs, request latch and read/merge capture.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_r      <= ST_IDLE;
         cs_r         <= 1'b0;
         we_r         <= 1'b0;
         ready_r      <= 1'b0;
         resp_valid_r <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         bus_dout_r   <= {DATA_W{1'b0}};
         rdata_r      <= {DATA_W{1'b0}};
`ifdef BYTE_STORE_EN
         be_r         <= {NUM_LANES{1'b0}};
`endif
      end else begin
         state_r      <= next_s;
         cs_r         <= cs_nx_s;
         we_r         <= we_nx_s;
         ready_r      <= (next_s == ST_IDLE) || (next_s == ST_RESP);
         resp_valid_r <= (next_s == ST_RESP);
         if (accept_s) begin
            addr_r     <= req_addr[ADDR_W+1:2];
            bus_dout_r <= req_wdata;
`ifdef BYTE_STORE_EN
            be_r       <= req_be;
`endif
         end
`ifdef BYTE_STORE_EN
         else if (state_r == ST_RMW_RD) begin
            bus_dout_r <= merged_s;
         end
`endif
         if (state_r == ST_RD) begin
            rdata_r <= Mem_Bus;
         end
      end
   end

   assign req_ready  = ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = rdata_r;
   assign CS         = cs_r;
   assign WE         = we_r;
   assign ADDR       = addr_r;

   // The controller drives the bus only during its own write cycles.
   assign Mem_Bus = we_r ? bus_dout_r : {DATA_W{1'bz}};

   // Address bits outside the word index alias and are deliberately dropped.
`ifdef BYTE_STORE_EN
   assign unused_s = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`else
   assign unused_s = ^{req_addr[31:ADDR_W+2], req_addr[1:0], req_be};
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: directed bench for mem_bus_ctrl with a falling-edge memory
// model on the shared bus and a per-cycle schedule of expected bus activity.
module tb_mem_bus_ctrl;

   localparam int NC = 4096;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        cs;
   logic        we;
   logic [6:0]  addr;
   wire  [31:0] mem_bus;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_ctrl #(.ADDR_W(7)) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_be     (req_be),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .CS         (cs),
      .WE         (we),
      .ADDR       (addr),
      .Mem_Bus    (mem_bus)
   );

   // Shared memory: writes and read-register updates on the falling edge.
   logic [31:0] env_mem [128];
   logic [31:0] rd_reg;
   logic        pre_we;
   logic [6:0]  pre_addr;
   logic [31:0] pre_data;

   always @(negedge clk) begin
      if (pre_we) env_mem[pre_addr] <= pre_data;
      else if (cs && we) env_mem[addr] <= mem_bus;
      if (cs && !we) rd_reg <= env_mem[addr];
   end
   assign mem_bus = (cs && !we) ? rd_reg : 32'bz;

   // Expected-behaviour model: memory image plus per-cycle expectations.
   logic [31:0] model_mem [128];
   logic [31:0] model_rdata;
   bit          exp_cs   [NC];
   bit          exp_we   [NC];
   bit          exp_resp [NC];
   bit          exp_busy [NC];
   bit          rd_upd   [NC];
   logic [6:0]  exp_addr [NC];
   logic [31:0] exp_wd   [NC];
   logic [31:0] rd_val   [NC];
   bit          chk_on;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Schedule what the bus and response must look like for a request that is
   // visible with ready high in cycle c0.
   task automatic sched(input int c0, input bit w, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
      int          wa;
      int          lat;
      logic [31:0] nw;
      wa = int'((a >> 2) & 32'h0000_007F);
      if (!w) begin
         lat = 2;
         exp_cs[c0+1]   = 1'b1;
         exp_addr[c0+1] = 7'(wa);
         rd_upd[c0+2]   = 1'b1;
         rd_val[c0+2]   = model_mem[wa];
      end else begin
         nw = model_mem[wa];
`ifdef BYTE_STORE_EN
         for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = d[8*i +: 8];
         if (be == 4'b0000) begin
            lat = 1;
         end else if (be == 4'b1111) begin
            lat = 2;
            exp_cs[c0+1] = 1'b1; exp_we[c0+1] = 1'b1;
            exp_addr[c0+1] = 7'(wa); exp_wd[c0+1] = nw;
         end else begin
            lat = 3;
            exp_cs[c0+1] = 1'b1; exp_addr[c0+1] = 7'(wa);
            exp_cs[c0+2] = 1'b1; exp_we[c0+2] = 1'b1;
            exp_addr[c0+2] = 7'(wa); exp_wd[c0+2] = nw;
         end
`else
         nw  = d;
         lat = 2;
         exp_cs[c0+1] = 1'b1; exp_we[c0+1] = 1'b1;
         exp_addr[c0+1] = 7'(wa); exp_wd[c0+1] = nw;
`endif
         model_mem[wa] = nw;
      end
      for (int k = 1; k < lat; k++) exp_busy[c0+k] = 1'b1;
      exp_resp[c0+lat] = 1'b1;
   endtask

   // A reset edge before cycle cr cancels everything still scheduled.
   task automatic reset_model(input int cr);
      for (int k = cr; k < cr + 8; k++) begin
         exp_cs[k] = 1'b0; exp_we[k] = 1'b0; exp_resp[k] = 1'b0;
         exp_busy[k] = 1'b0; rd_upd[k] = 1'b0;
      end
      exp_busy[cr] = 1'b1;
      rd_upd[cr]   = 1'b1;
      rd_val[cr]   = 32'h0;
   endtask

   // Per-cycle comparison of DUT outputs against the schedule.
   always @(negedge clk) begin
      if (chk_on) begin
         if (rd_upd[cyc]) model_rdata = rd_val[cyc];
         chk("req_ready", 32'(req_ready), 32'(!exp_busy[cyc]));
         chk("cs", 32'(cs), 32'(exp_cs[cyc]));
         chk("we", 32'(we), 32'(exp_we[cyc]));
         chk("resp_valid", 32'(resp_valid), 32'(exp_resp[cyc]));
         chk("resp_rdata", resp_rdata, model_rdata);
         if (exp_cs[cyc]) chk("addr", 32'(addr), 32'(exp_addr[cyc]));
         if (exp_we[cyc]) chk("bus_wdata", mem_bus, exp_wd[cyc]);
      end
   end

   // Present a request, hold it until accepted, return its cycle 0.
   // Returns #1 after the accept edge (i.e. inside cycle 1).
   task automatic do_req(input bit w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, output int c0);
      int n;
      n  = 0;
      c0 = -1;
      req_valid = 1'b1; req_we = w; req_addr = a; req_be = be; req_wdata = d;
      while (c0 < 0 && n < 50) begin
         @(negedge clk);
         if (req_ready) begin
            c0 = cyc;
            sched(c0, w, a, be, d);
         end
         n++;
      end
      if (c0 < 0) chk("accept_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int          c0;
   int          c1;
   logic [31:0] saved;

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
      req_be = 4'h0; req_wdata = 32'h0; pre_we = 1'b0; pre_addr = 7'h0;
      pre_data = 32'h0; chk_on = 1'b0; model_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 128; i++) begin
         pre_we   = 1'b1;
         pre_addr = 7'(i);
         if (i == 4)      pre_data = 32'hDEAD_BEEF;
         else if (i == 5) pre_data = 32'h1122_3344;
         else             pre_data = 32'hC0DE_0000 | 32'(i);
         model_mem[i] = pre_data;
         @(posedge clk); #1;
      end
      pre_we = 1'b0;

      // Reset state.
      @(negedge clk);
      chk("rst_cs", 32'(cs), 32'h0);
      chk("rst_we", 32'(we), 32'h0);
      chk("rst_addr", 32'(addr), 32'h0);
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      chk_on = 1'b1;

      // Load of word 4.
      do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, c0);
      chk("ld_cs_c1", 32'(cs), 32'h1);
      chk("ld_we_c1", 32'(we), 32'h0);
      chk("ld_addr_c1", 32'(addr), 32'h4);
      @(negedge clk); @(negedge clk);
      chk("ld_resp_c2", 32'(resp_valid), 32'h1);
      chk("ld_data_c2", resp_rdata, 32'hDEAD_BEEF);
      idle(2);

      // Full store then back-to-back load of the same word.
      do_req(1'b1, 32'h0000_000C, 4'hF, 32'h1234_5678, c0);
      do_req(1'b0, 32'h0000_000C, 4'h0, 32'h0, c1);
      chk("b2b_accept_gap", 32'(c1 - c0), 32'h2);
      idle(4);
      chk("st_mem_word3", env_mem[3], 32'h1234_5678);
      chk("b2b_ld_data", resp_rdata, 32'h1234_5678);

      // Partial store into word 5.
      do_req(1'b1, 32'h0000_0014, 4'b0010, 32'h0000_AB00, c0);
      idle(4);
`ifdef BYTE_STORE_EN
      chk("part_mem_word5", env_mem[5], 32'h1122_AB44);
`else
      chk("part_mem_word5", env_mem[5], 32'h0000_AB00);
`endif

      // Empty byte-enable store to word 6.
      do_req(1'b1, 32'h0000_0018, 4'b0000, 32'hFFFF_FFFF, c0);
      idle(4);
`ifdef BYTE_STORE_EN
      chk("be0_mem_word6", env_mem[6], 32'hC0DE_0006);
`else
      chk("be0_mem_word6", env_mem[6], 32'hFFFF_FFFF);
`endif

      // Address aliasing.
      do_req(1'b0, 32'h0000_0200, 4'h0, 32'h0, c0);
      chk("alias_addr0", 32'(addr), 32'h0);
      idle(3);
      chk("alias_data0", resp_rdata, 32'hC0DE_0000);
      do_req(1'b0, 32'hFFFF_FE11, 4'h0, 32'h0, c0);
      chk("alias_addr4", 32'(addr), 32'h4);
      idle(3);

      // Back-to-back full stores.
      do_req(1'b1, 32'h0000_0020, 4'hF, 32'hA5A5_0008, c0);
      do_req(1'b1, 32'h0000_0024, 4'hF, 32'h5A5A_0009, c0);
      idle(3);

      // Reset during the cycle after accepting a partial store to word 7.
      saved = model_mem[7];
      do_req(1'b1, 32'h0000_001C, 4'b0100, 32'h0055_0000, c0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      reset_model(c0 + 2);
`ifdef BYTE_STORE_EN
      model_mem[7] = saved;
`endif
      rst_n = 1'b1;
      chk("rst_mid_cs", 32'(cs), 32'h0);
      chk("rst_mid_we", 32'(we), 32'h0);
      chk("rst_mid_resp", 32'(resp_valid), 32'h0);
      idle(3);
`ifdef BYTE_STORE_EN
      chk("rst_mid_word7", env_mem[7], 32'hC0DE_0007);
`else
      chk("rst_mid_word7", env_mem[7], 32'h0055_0000);
`endif

      // Recovery load after the reset.
      do_req(1'b0, 32'h0000_0014, 4'h0, 32'h0, c0);
      idle(4);

      chk_on = 1'b0;
      for (int i = 0; i < 128; i++) chk("mem_image", env_mem[i], model_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1);
   end

endmodule
